// File: rtl/adc_spi_pkg.sv
// Shared constants, FSM state type and result-word packing for the ADC SPI responder.
package adc_spi_pkg;

  localparam int FRAME_BITS = 16;
  localparam int SAMPLE_W   = 12;
  localparam int WRITE_BIT  = 15;
  localparam int ADDR_MSB   = 12;
  localparam int ADDR_LSB   = 10;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  function automatic logic [FRAME_BITS-1:0] mk_result(input logic [2:0]          addr,
                                                     input logic [SAMPLE_W-1:0] sample);
    return {1'b0, addr, sample};
  endfunction

endpackage

// File: rtl/spi_in_sync.sv
// Multi-flop synchronizers for the asynchronous SPI pins plus registered edge detection.
module spi_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_cs_n,
  input  logic i_sclk,
  input  logic i_din,
  output logic o_cs_s,
  output logic o_cs_fall,
  output logic o_cs_rise,
  output logic o_sclk_rise,
  output logic o_sclk_fall,
  output logic o_din_s
);

  logic [SYNC_STAGES-1:0] r_cs, r_sclk, r_din;
  logic                   r_cs_q, r_sclk_q;

  // CS resets to the "selected" level so a frame already running when reset
  // drops does not look like a fresh CS fall.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cs     <= '0;
      r_sclk   <= '0;
      r_din    <= '0;
      r_cs_q   <= 1'b0;
      r_sclk_q <= 1'b0;
    end else begin
      r_cs     <= {r_cs[SYNC_STAGES-2:0], i_cs_n};
      r_sclk   <= {r_sclk[SYNC_STAGES-2:0], i_sclk};
      r_din    <= {r_din[SYNC_STAGES-2:0], i_din};
      r_cs_q   <= r_cs[SYNC_STAGES-1];
      r_sclk_q <= r_sclk[SYNC_STAGES-1];
    end
  end

  assign o_cs_s      = r_cs[SYNC_STAGES-1];
  assign o_cs_fall   = r_cs_q & ~r_cs[SYNC_STAGES-1];
  assign o_cs_rise   = ~r_cs_q & r_cs[SYNC_STAGES-1];
  assign o_sclk_rise = ~r_sclk_q & r_sclk[SYNC_STAGES-1];
  assign o_sclk_fall = r_sclk_q & ~r_sclk[SYNC_STAGES-1];
  assign o_din_s     = r_din[SYNC_STAGES-1];

endmodule

// File: rtl/adc_spi_responder.sv
// SPI target emulating an 8-channel 12-bit serial ADC: captures the control word and
// returns {0, addr, sample} for the channel selected by the previous frame.
module adc_spi_responder
  import adc_spi_pkg::*;
#(
  parameter int NUM_CH      = 8,
  parameter int DATA_W      = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     spi_cs_n,
  input  logic                     spi_sclk,
  input  logic                     spi_din,
  output logic                     spi_dout,
  input  logic [NUM_CH*DATA_W-1:0] sample_bus,
  output logic [FRAME_BITS-1:0]    ctrl_word,
  output logic                     ctrl_valid,
  output logic [2:0]               cur_ch,
  output logic                     frame_err,
  output logic                     busy
);

  localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS - 1);

  function automatic logic [2:0] wrap_ch(input logic [2:0] a);
    return 3'(32'(a) % NUM_CH);
  endfunction

  logic w_cs_s, w_cs_fall, w_cs_rise, w_sclk_rise, w_sclk_fall, w_din_s;

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_cs_n      (spi_cs_n),
    .i_sclk      (spi_sclk),
    .i_din       (spi_din),
    .o_cs_s      (w_cs_s),
    .o_cs_fall   (w_cs_fall),
    .o_cs_rise   (w_cs_rise),
    .o_sclk_rise (w_sclk_rise),
    .o_sclk_fall (w_sclk_fall),
    .o_din_s     (w_din_s)
  );

  logic [DATA_W-1:0] w_samples [NUM_CH];
  for (genvar k = 0; k < NUM_CH; k++) begin : g_smp
    assign w_samples[k] = sample_bus[k*DATA_W +: DATA_W];
  end

  logic [FRAME_BITS-1:0] w_tx_snap;
  assign w_tx_snap = mk_result(cur_ch, w_samples[cur_ch]);

  state_t                r_state, w_state_nxt;
  logic [FRAME_BITS-1:0] r_tx, r_rx;
  logic [4:0]            r_bit_cnt;
  logic                  r_done_first;
  logic                  w_start, w_rise, w_fall, w_abort, w_to_done, w_done_exit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // A 16th rise coinciding with the CS rise completes the frame; DONE then
  // exits on the CS level so that coincident rise is not lost.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_rise      = 1'b0;
    w_fall      = 1'b0;
    w_abort     = 1'b0;
    w_to_done   = 1'b0;
    w_done_exit = 1'b0;
    case (r_state)
      IDLE: if (w_cs_fall) begin
        w_start     = 1'b1;
        w_state_nxt = SHIFT;
      end
      SHIFT: begin
        if (w_sclk_rise && r_bit_cnt == LAST_BIT) begin
          w_rise      = 1'b1;
          w_to_done   = 1'b1;
          w_state_nxt = DONE;
        end else if (w_cs_rise) begin
          w_abort     = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_rise = w_sclk_rise;
          w_fall = w_sclk_fall;
        end
      end
      DONE: if (w_cs_s) begin
        w_done_exit = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spi_dout     <= 1'b0;
      r_tx         <= '0;
      r_rx         <= '0;
      r_bit_cnt    <= '0;
      ctrl_word    <= '0;
      ctrl_valid   <= 1'b0;
      cur_ch       <= '0;
      frame_err    <= 1'b0;
      busy         <= 1'b0;
      r_done_first <= 1'b0;
    end else begin
      ctrl_valid   <= 1'b0;
      frame_err    <= 1'b0;
      r_done_first <= w_to_done;
      if (w_start) begin
        r_tx      <= w_tx_snap;
        spi_dout  <= w_tx_snap[FRAME_BITS-1];
        r_bit_cnt <= '0;
        busy      <= 1'b1;
      end
      if (w_rise) begin
        r_rx      <= {r_rx[FRAME_BITS-2:0], w_din_s};
        r_bit_cnt <= r_bit_cnt + 5'd1;
      end
      if (w_fall) spi_dout <= r_tx[4'(FRAME_BITS-1) - r_bit_cnt[3:0]];
      if (w_abort) begin
        frame_err <= 1'b1;
        spi_dout  <= 1'b0;
        busy      <= 1'b0;
        r_rx      <= '0;
      end
      if (r_done_first) begin
        ctrl_word  <= r_rx;
        ctrl_valid <= 1'b1;
        spi_dout   <= 1'b0;
        if (r_rx[WRITE_BIT]) cur_ch <= wrap_ch(r_rx[ADDR_MSB:ADDR_LSB]);
      end
      if (w_done_exit) busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed + randomized frames against a word-level ADC model (pipelined address, snapshot, errors).
module tb_adc_spi_responder;
  localparam int NUM_CH = 8;
  localparam int DATA_W = 12;
  localparam int SS     = 2;
  localparam int HP     = 6;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     spi_cs_n = 1'b1;
  logic                     spi_sclk = 1'b0;
  logic                     spi_din = 1'b0;
  logic                     spi_dout;
  logic [NUM_CH*DATA_W-1:0] sample_bus = '0;
  logic [15:0]              ctrl_word;
  logic                     ctrl_valid;
  logic [2:0]               cur_ch;
  logic                     frame_err;
  logic                     busy;

  int errs = 0, checks = 0;
  int cyc = 0, n_valid = 0, n_ferr = 0, valid_cyc = 0, t16 = 0;

  logic [11:0] smp [NUM_CH];
  logic [2:0]  m_ch   = 3'd0;
  logic [15:0] m_ctrl = 16'h0;

  adc_spi_responder #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .SYNC_STAGES(SS)) dut (
    .clk        (clk),
    .rst        (rst),
    .spi_cs_n   (spi_cs_n),
    .spi_sclk   (spi_sclk),
    .spi_din    (spi_din),
    .spi_dout   (spi_dout),
    .sample_bus (sample_bus),
    .ctrl_word  (ctrl_word),
    .ctrl_valid (ctrl_valid),
    .cur_ch     (cur_ch),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (ctrl_valid) begin
      n_valid   = n_valid + 1;
      valid_cyc = cyc;
    end
    if (frame_err) n_ferr = n_ferr + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic upd_bus();
    for (int k = 0; k < NUM_CH; k++) sample_bus[k*DATA_W +: DATA_W] = smp[k];
  endtask

  // Drives one CS-low window with nrise SCLK pulses; collects DOUT just before each rise.
  task automatic run_frame(input logic [15:0] w, input int nrise, input int rst_at,
                           input bit chg, output logic [15:0] got, output int extra);
    got   = '0;
    extra = 0;
    spi_din  = w[15];
    spi_cs_n = 1'b0;
    wait_clk(HP);
    for (int i = 0; i < nrise; i++) begin
      if (i == rst_at) begin
        rst = 1'b1;
        #1;
        chk("rst_mid_dout", {31'd0, spi_dout}, 32'd0);
        chk("rst_mid_ctrl_word", {16'd0, ctrl_word}, 32'd0);
        chk("rst_mid_cur_ch", {29'd0, cur_ch}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_valid_err", {30'd0, ctrl_valid, frame_err}, 32'd0);
        wait_clk(2);
        rst = 1'b0;
      end
      if (i == 8 && rst_at < 0) chk("busy_mid", {31'd0, busy}, 32'd1);
      if (i < 16) got[15-i] = spi_dout;
      else if (spi_dout !== 1'b0) extra++;
      if (chg && i == 3) begin
        for (int k = 0; k < NUM_CH; k++) smp[k] = 12'($urandom);
        upd_bus();
      end
      spi_sclk = 1'b1;
      if (i == 15) t16 = cyc;
      wait_clk(HP);
      spi_sclk = 1'b0;
      spi_din  = (i < 15) ? w[14-i] : 1'b0;
      wait_clk(HP);
    end
    spi_cs_n = 1'b1;
    wait_clk(HP + 2);
  endtask

  task automatic full_frame(input string tag, input logic [15:0] w, input int nrise, input bit chg);
    logic [15:0] got, exp;
    int          ex, v0, f0;
    exp = {1'b0, m_ch, smp[m_ch]};
    v0  = n_valid;
    f0  = n_ferr;
    run_frame(w, nrise, -1, chg, got, ex);
    m_ctrl = w;
    if (w[15]) m_ch = w[12:10];
    chk({tag, "_dout"}, {16'd0, got}, {16'd0, exp});
    chk({tag, "_ctrl_word"}, {16'd0, ctrl_word}, {16'd0, m_ctrl});
    chk({tag, "_valid_cnt"}, n_valid - v0, 32'd1);
    chk({tag, "_ferr_cnt"}, n_ferr - f0, 32'd0);
    chk({tag, "_cur_ch"}, {29'd0, cur_ch}, {29'd0, m_ch});
    chk({tag, "_idle"}, {30'd0, busy, spi_dout}, 32'd0);
    if (nrise > 16) chk({tag, "_extra_dout"}, ex, 32'd0);
  endtask

  initial begin
    logic [15:0] got;
    int          ex, v0, f0;
    for (int k = 0; k < NUM_CH; k++) smp[k] = 12'($urandom);
    upd_bus();

    wait_clk(3);
    chk("rst_dout", {31'd0, spi_dout}, 32'd0);
    chk("rst_ctrl_word", {16'd0, ctrl_word}, 32'd0);
    chk("rst_cur_ch", {29'd0, cur_ch}, 32'd0);
    chk("rst_flags", {29'd0, ctrl_valid, frame_err, busy}, 32'd0);
    rst = 1'b0;
    wait_clk(4);

    // T1 / T2 / T3
    smp[0] = 12'h123;
    upd_bus();
    full_frame("t1", 16'h8C31, 16, 1'b0);
    chk("t1_latency", valid_cyc - t16, SS + 2);
    smp[3] = 12'hABC;
    upd_bus();
    full_frame("t2", 16'h9C31, 16, 1'b0);
    full_frame("t3", 16'h0C31, 16, 1'b0);

    // T4 early CS deassert, then a clean frame
    v0 = n_valid;
    f0 = n_ferr;
    run_frame(16'h9431, 9, -1, 1'b0, got, ex);
    chk("t4_ferr_cnt", n_ferr - f0, 32'd1);
    chk("t4_valid_cnt", n_valid - v0, 32'd0);
    chk("t4_cur_ch", {29'd0, cur_ch}, {29'd0, m_ch});
    chk("t4_ctrl_word", {16'd0, ctrl_word}, {16'd0, m_ctrl});
    chk("t4_idle", {30'd0, busy, spi_dout}, 32'd0);
    full_frame("t4_next", 16'h8831, 16, 1'b1);

    // T5 extra SCLK cycles
    full_frame("t5", 16'hD5A5, 20, 1'b1);

    // T6 reset at bit 6, frame remainder ignored, next frame reports ch0
    full_frame("t6_pre", 16'h9400, 16, 1'b0);
    v0 = n_valid;
    f0 = n_ferr;
    run_frame(16'h9C00, 16, 6, 1'b0, got, ex);
    m_ch   = 3'd0;
    m_ctrl = 16'h0;
    chk("t6_valid_cnt", n_valid - v0, 32'd0);
    chk("t6_ferr_cnt", n_ferr - f0, 32'd0);
    chk("t6_ctrl_word", {16'd0, ctrl_word}, 32'd0);
    chk("t6_cur_ch", {29'd0, cur_ch}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    full_frame("t6_next", 16'($urandom), 16, 1'b1);

    for (int n = 0; n < 8; n++)
      full_frame("rnd", 16'($urandom), 16 + int'($urandom_range(0, 4)), 1'b1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
